// File: rtl/pulse_stretcher_pkg.sv
// Shared definitions for the pulse stretcher.
//   pulse_stretcher_state_t : FSM state encoding (IDLE / ACTIVE / GAP)
//   cnt_width()             : width of the shared ACTIVE/GAP down-counter
package pulse_stretcher_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } pulse_stretcher_state_t;

    // The counter holds at most max(high, gap) - 1. Clamp to one bit so a
    // 1/1 configuration still gets a legal vector.
    function automatic int cnt_width(input int high_cycles, input int gap_cycles);
        int m;
        m = (high_cycles > gap_cycles) ? high_cycles : gap_cycles;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/pulse_stretcher.sv
// Pulse stretcher: turns single-cycle request pulses into fixed-width active
// levels, each followed by a guaranteed idle gap. Requests arriving while a
// window or gap is in progress are queued in a saturating pending counter.
//
// Ports:
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   clk_en        clock enable; state only advances on enabled edges
//   pulse_in      request pulse, sampled on enabled edges
//   out           stretched level (registered)
//   busy          high while not IDLE (registered)
//   pending_count queued requests not yet started (registered)
//   overflow      one-clk pulse when a request is dropped (registered)
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int HIGH_CYCLES = 4,
    parameter int GAP_CYCLES  = 1,
    parameter int MAX_PENDING = 3,
    parameter bit OUT_LEVEL   = 1'b1,
    parameter int PEND_W      = $clog2(MAX_PENDING + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clk_en,
    input  logic              pulse_in,
    output logic              out,
    output logic              busy,
    output logic [PEND_W-1:0] pending_count,
    output logic              overflow
);

    localparam int                CNT_W     = cnt_width(HIGH_CYCLES, GAP_CYCLES);
    localparam logic [CNT_W-1:0]  HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(MAX_PENDING);

    if (HIGH_CYCLES < 1) begin : g_bad_high
        $error("pulse_stretcher: HIGH_CYCLES must be >= 1");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap
        $error("pulse_stretcher: GAP_CYCLES must be >= 1");
    end
    if (MAX_PENDING < 1) begin : g_bad_pend
        $error("pulse_stretcher: MAX_PENDING must be >= 1");
    end

    pulse_stretcher_state_t state, next_state;
    logic [CNT_W-1:0]       cnt, next_cnt;
    logic [PEND_W-1:0]      next_pend;
    logic                   start;      // this edge enters ACTIVE
    logic                   consume;    // the start is served from the queue
    logic                   queue_req;  // pulse_in must be queued rather than started
    logic                   drop;

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        next_pend  = pending_count;
        start      = 1'b0;
        consume    = 1'b0;
        queue_req  = 1'b0;
        drop       = 1'b0;

        case (state)
            IDLE: begin
                start = pulse_in;
            end
            ACTIVE: begin
                queue_req = pulse_in;
                if (cnt != '0) begin
                    next_cnt = cnt - CNT_W'(1);
                end else begin
                    next_state = GAP;
                    next_cnt   = GAP_LOAD;
                end
            end
            GAP: begin
                if (cnt != '0) begin
                    next_cnt  = cnt - CNT_W'(1);
                    queue_req = pulse_in;
                end else if (pending_count != '0) begin
                    // Oldest queued request goes first; a same-edge pulse
                    // takes its place in the queue.
                    start     = 1'b1;
                    consume   = 1'b1;
                    queue_req = pulse_in;
                end else if (pulse_in) begin
                    start = 1'b1;
                end else begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
                next_cnt   = '0;
            end
        endcase

        if (start) begin
            next_state = ACTIVE;
            next_cnt   = HIGH_LOAD;
        end

        // Consume and arrival on the same edge cancel, which also means a
        // full queue does not drop in that case.
        if (consume && !queue_req) begin
            next_pend = pending_count - PEND_W'(1);
        end else if (!consume && queue_req) begin
            if (pending_count == PEND_MAX) drop = 1'b1;
            else                           next_pend = pending_count + PEND_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            cnt           <= '0;
            pending_count <= '0;
            out           <= ~OUT_LEVEL;
            busy          <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            // overflow self-clears on any edge, enabled or not
            overflow <= clk_en & drop;
            if (clk_en) begin
                state         <= next_state;
                cnt           <= next_cnt;
                pending_count <= next_pend;
                out           <= (next_state == ACTIVE) ? OUT_LEVEL : ~OUT_LEVEL;
                busy          <= (next_state != IDLE);
            end
        end
    end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Self-checking bench for pulse_stretcher (default parameters).
module tb_pulse_stretcher;

    localparam int H    = 4;
    localparam int G    = 1;
    localparam int MAXP = 3;
    localparam int PW   = $clog2(MAXP + 1);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          clk_en = 1'b0;
    logic          pulse_in = 1'b0;
    logic          out, busy, overflow;
    logic [PW-1:0] pending_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pulse_stretcher #(
        .HIGH_CYCLES(H),
        .GAP_CYCLES (G),
        .MAX_PENDING(MAXP),
        .OUT_LEVEL  (1'b1)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .clk_en       (clk_en),
        .pulse_in     (pulse_in),
        .out          (out),
        .busy         (busy),
        .pending_count(pending_count),
        .overflow     (overflow)
    );

    typedef struct {
        bit en;
        bit p;
        bit o;
        bit b;
        int pd;
        bit ov;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit en, input bit p, input bit o, input bit b,
                       input int pd, input bit ov);
        vec_t v;
        v.en = en; v.p = p; v.o = o; v.b = b; v.pd = pd; v.ov = ov;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // inputs are changed at the falling edge; outputs are sampled there too
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_all(input string tag, input bit o, input bit b,
                             input int pd, input bit ov);
        check({tag, ".out"},      int'(out), int'(o));
        check({tag, ".busy"},     int'(busy), int'(b));
        check({tag, ".pending"},  int'(pending_count), pd);
        check({tag, ".overflow"}, int'(overflow), int'(ov));
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        clk_en   = 1'b0;
        pulse_in = 1'b0;
        tick();
        tick();
        check_all("reset", 1'b0, 1'b0, 0, 1'b0);
        reset_n = 1'b1;
    endtask

    // Timeline model: windows start at enabled-edge index s; out is active
    // for H edges from s, busy for H+G edges, and the next window may start
    // no earlier than s+H+G.
    int m_k, m_s, m_pend;
    bit m_have, m_ovf;

    task automatic model_reset();
        m_k = -1; m_s = 0; m_pend = 0; m_have = 0; m_ovf = 0;
    endtask

    task automatic model_step(input bit en, input bit p);
        m_ovf = 0;
        if (!en) return;
        m_k++;
        if (!m_have || m_k >= m_s + H + G) begin
            if (m_pend > 0) begin
                m_have = 1; m_s = m_k;
                if (!p) m_pend--;
            end else if (p) begin
                m_have = 1; m_s = m_k;
            end
        end else if (p) begin
            if (m_pend < MAXP) m_pend++;
            else               m_ovf = 1;
        end
    endtask

    function automatic bit model_out();
        return m_have && (m_k - m_s) < H;
    endfunction

    function automatic bit model_busy();
        return m_have && (m_k - m_s) < H + G;
    endfunction

    initial begin
        int rises, guard;
        bit prev, done;

        // single pulse from idle
        add(1,1, 1,1,0,0); add(1,0, 1,1,0,0); add(1,0, 1,1,0,0); add(1,0, 1,1,0,0);
        add(1,0, 0,1,0,0); add(1,0, 0,0,0,0); add(1,0, 0,0,0,0);
        // pulse on the gap's last edge with nothing queued starts directly
        add(1,1, 1,1,0,0); add(1,0, 1,1,0,0); add(1,0, 1,1,0,0); add(1,0, 1,1,0,0);
        add(1,0, 0,1,0,0); add(1,1, 1,1,0,0); add(1,0, 1,1,0,0); add(1,0, 1,1,0,0);
        add(1,0, 1,1,0,0); add(1,0, 0,1,0,0); add(1,0, 0,0,0,0);
        // back-to-back: pulses at e0 and e2
        add(1,1, 1,1,0,0); add(1,0, 1,1,0,0); add(1,1, 1,1,1,0); add(1,0, 1,1,1,0);
        add(1,0, 0,1,1,0); add(1,0, 1,1,0,0); add(1,0, 1,1,0,0); add(1,0, 1,1,0,0);
        add(1,0, 1,1,0,0); add(1,0, 0,1,0,0); add(1,0, 0,0,0,0);
        // same-edge consume and arrival keeps pending at 1
        add(1,1, 1,1,0,0); add(1,0, 1,1,0,0); add(1,1, 1,1,1,0); add(1,0, 1,1,1,0);
        add(1,0, 0,1,1,0); add(1,1, 1,1,1,0); add(1,0, 1,1,1,0); add(1,0, 1,1,1,0);
        add(1,0, 1,1,1,0); add(1,0, 0,1,1,0); add(1,0, 1,1,0,0); add(1,0, 1,1,0,0);
        add(1,0, 1,1,0,0); add(1,0, 1,1,0,0); add(1,0, 0,1,0,0); add(1,0, 0,0,0,0);
        // disabled edges freeze everything and ignore pulse_in
        add(0,1, 0,0,0,0); add(0,1, 0,0,0,0);

        @(negedge clk);
        do_reset();

        foreach (vecs[i]) begin
            clk_en   = vecs[i].en;
            pulse_in = vecs[i].p;
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].o, vecs[i].b, vecs[i].pd, vecs[i].ov);
        end

        // overflow: five consecutive pulses, the fifth is dropped
        clk_en = 1'b1;
        rises  = 0;
        prev   = out;
        for (int i = 0; i < 5; i++) begin
            pulse_in = 1'b1;
            tick();
            if (out && !prev) rises++;
            prev = out;
            if (i == 3) check("ovf.pend_full", int'(pending_count), 3);
        end
        check("ovf.flag",     int'(overflow), 1);
        check("ovf.pend_hold", int'(pending_count), 3);
        pulse_in = 1'b0;
        tick();
        if (out && !prev) rises++;
        prev = out;
        check("ovf.flag_clear", int'(overflow), 0);
        done = 0;
        for (guard = 0; guard < 60 && !done; guard++) begin
            tick();
            if (out && !prev) rises++;
            prev = out;
            if (!busy) done = 1;
        end
        check("ovf.drain_in_time", int'(done), 1);
        check("ovf.windows", rises, 4);

        // clk_en every third clock: 4 enabled edges = 12 clocks of active out
        clk_en   = 1'b0;
        pulse_in = 1'b1;
        repeat (3) tick();
        check("en.ignored_out",  int'(out), 0);
        check("en.ignored_busy", int'(busy), 0);
        clk_en = 1'b1;
        tick();
        pulse_in = 1'b0;
        rises = out ? 1 : 0;
        done  = 0;
        for (int i = 1; i < 100 && !done; i++) begin
            clk_en = (i % 3 == 0);
            tick();
            if (out) rises++;
            else     done = 1;
        end
        check("en.stretch_done", int'(done), 1);
        check("en.active_clks",  rises, 12);
        clk_en = 1'b1;
        repeat (4) tick();

        // async reset mid-ACTIVE with two queued requests
        pulse_in = 1'b1;
        repeat (3) tick();
        pulse_in = 1'b0;
        check("rst.pre_pend", int'(pending_count), 2);
        #1 reset_n = 1'b0;
        #1;
        check_all("rst.async", 1'b0, 1'b0, 0, 1'b0);
        tick();
        reset_n = 1'b1;
        pulse_in = 1'b1;
        tick();
        check_all("rst.e0", 1'b1, 1'b1, 0, 1'b0);
        pulse_in = 1'b0;
        repeat (3) tick();
        check("rst.e3_out", int'(out), 1);
        tick();
        check_all("rst.e4", 1'b0, 1'b1, 0, 1'b0);
        tick();
        check_all("rst.e5", 1'b0, 1'b0, 0, 1'b0);

        // randomized against the timeline model
        do_reset();
        model_reset();
        for (int i = 0; i < 1500; i++) begin
            clk_en   = ($urandom_range(9) < 7);
            pulse_in = ($urandom_range(9) < 4);
            tick();
            model_step(clk_en, pulse_in);
            if (int'(out) != int'(model_out()) || int'(busy) != int'(model_busy()) ||
                int'(pending_count) != m_pend || int'(overflow) != int'(m_ovf))
                check_all($sformatf("rnd%0d", i), model_out(), model_busy(), m_pend, m_ovf);
            else
                n_tests++;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
- Converts single-cycle request pulses into clean, fixed-width output levels, each followed by a guaranteed inactive gap.
- Every accepted pulse produces exactly one detectable edge at the far end.
- Requests that arrive during an active output or gap are queued in a saturating pending counter.
- Sits in the misc library; drives slow peripheral strobes (DAC latch, LED, IRQ line) from single-cycle event pulses in the clk_en-gated sample domain.

Parameters:
- HIGH_CYCLES, 4, enabled cycles the output holds the active level per request (>=1).
- GAP_CYCLES, 1, enabled cycles the output holds the idle level between requests (>=1; 0 is illegal and is rejected by an elaboration assertion).
- MAX_PENDING, 3, maximum queued requests (>=1).
- OUT_LEVEL, 1, active output level; idle level is !OUT_LEVEL.
- PEND_W, $clog2(MAX_PENDING+1), width of pending_count (derived; do not override).

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- clk_en  input  1  clock enable; all counting and sampling happen only when high
- pulse_in  input  1  request pulse, synchronous to clk, sampled only when clk_en=1
- out  output  1  stretched level, registered
- busy  output  1  high while state != IDLE, registered
- pending_count  output  PEND_W  queued requests not yet started, registered
- overflow  output  1  one-clk pulse when a request is dropped, registered

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, out=!OUT_LEVEL, busy=0, pending_count=0, overflow=0, counter=0.
  - Reset mid-operation aborts immediately and discards queued requests.
- All state, counter and pending updates occur only on clk edges with clk_en=1. overflow is the exception: it clears on the next clk edge regardless of clk_en.
- States: IDLE, ACTIVE, GAP. cnt is the internal down-counter, width $clog2(max(HIGH_CYCLES,GAP_CYCLES)).
- IDLE:
  - On pulse_in=1: go to ACTIVE; out<=OUT_LEVEL; cnt<=HIGH_CYCLES-1.
  - Latency is one clk: out changes on the same edge that samples pulse_in.
- ACTIVE:
  - While cnt!=0: cnt--.
  - When cnt==0: go to GAP; out<=!OUT_LEVEL; cnt<=GAP_CYCLES-1.
  - Result: out is active for exactly HIGH_CYCLES enabled edges.
- GAP:
  - While cnt!=0: cnt--.
  - When cnt==0 and (pending_count>0 or pulse_in): go to ACTIVE; out<=OUT_LEVEL; cnt<=HIGH_CYCLES-1. A queued request is consumed first.
  - When cnt==0 otherwise: go to IDLE.
- Queueing:
  - A pulse_in accepted in ACTIVE or GAP that does not start ACTIVE this edge increments pending_count.
  - Same-edge consume and new pulse: pending_count is unchanged.
  - Consume with no new pulse: pending_count decrements.
  - pulse_in in GAP at cnt==0 with pending_count==0 starts ACTIVE directly; pending_count stays 0.
- Saturation: a pulse arriving with pending_count==MAX_PENDING and no same-edge consume is dropped. overflow<=1 for one clk; pending_count holds.
- busy is high from the edge that enters ACTIVE until the edge that returns to IDLE.
- pulse_in held high for several enabled cycles counts as several requests. No internal edge detection is performed.
- clk_en low freezes everything, including out.

Decomposition:
- Shared misc package holds:
  - typedef enum logic [1:0] {IDLE, ACTIVE, GAP} pulse_stretcher_state_t
  - a localparam helper for counter width
- No sub-module. The FSM, down-counter and pending counter are one always_ff plus one next-state always_comb, about 150 lines.

Test Plan:
- Single pulse, clk_en=1, defaults: pulse at edge e0 -> out=1 after e0 through e4, 0 at e4, busy=0 after e5, pending stays 0.
- Back-to-back: pulses at e0 and e2 -> pending_count=1 after e2; out high e0–e4, low e4–e5, high again e5–e9, pending_count=0 after e5.
- Overflow: MAX_PENDING=3, pulses at e0..e4 consecutive -> pending reaches 3 at e3; e4 pulse dropped, overflow=1 for one clk after e4; exactly 4 active windows total.
- Simultaneous consume and arrival: pending=1, pulse on the GAP cnt==0 edge -> ACTIVE entered, pending_count remains 1.
- clk_en=1 every 3rd clk: single pulse -> out active for exactly 4 enabled edges (12 clks); pulse_in asserted while clk_en=0 is ignored.
- Async reset mid-ACTIVE with pending=2: reset_n low between edges -> out=0, busy=0, pending=0 immediately without a clk edge; first pulse after release behaves as in the first scenario.
